// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS): one transaction
// in flight, registered memory-side request, combinational grant/response routing, response timeout.
module mem_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          DATA_PRIO = 1'b0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic             ls_gnt,
  output logic             ls_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             rerr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             timeout_flg
);

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp} state_e;

  state_e          state_q;
  logic            owner_ls_q;  // owner of the current (or most recent) transaction, 1 = LS
  logic [CntW-1:0] cnt_q;
  logic            pick_ls;
  logic            gnt_fire;
  logic            rsp_ok;
  logic            rsp_abort;

  always_comb begin
    // Ties go to LS under data priority, otherwise away from the previous owner.
    pick_ls   = ls_req && (!if_req || DATA_PRIO || !owner_ls_q);
    gnt_fire  = (state_q == StIssue) && mem_gnt;
    rsp_ok    = (state_q == StWaitResp) && mem_rvalid;
    rsp_abort = (state_q == StWaitResp) && !mem_rvalid && (cnt_q == CntLast);
  end

  always_comb begin
    if_gnt    = gnt_fire && !owner_ls_q;
    ls_gnt    = gnt_fire && owner_ls_q;
    if_rvalid = (rsp_ok || rsp_abort) && !owner_ls_q;
    ls_rvalid = (rsp_ok || rsp_abort) && owner_ls_q;
    rerr      = rsp_abort;
    rdata     = rsp_ok ? mem_rdata : '0;
    busy      = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_ls_q  <= 1'b1;
      cnt_q       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_flg <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // A response with nothing outstanding is stray.
          if (mem_rvalid) timeout_flg <= 1'b1;
          if (if_req || ls_req) begin
            owner_ls_q <= pick_ls;
            mem_req    <= 1'b1;
            mem_we     <= pick_ls && ls_we;
            mem_addr   <= pick_ls ? ls_addr : if_addr;
            mem_wdata  <= pick_ls ? ls_wdata : '0;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (mem_rvalid) timeout_flg <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt_q   <= '0;
            state_q <= StWaitResp;
          end
        end
        StWaitResp: begin
          if (mem_rvalid) begin
            state_q <= StIdle;
          end else if (cnt_q == CntLast) begin
            timeout_flg <= 1'b1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a scheduled driver/memory model pushes expected
// requests, grants and responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  localparam int TO = 4;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; int cyc;} req_t;
  typedef struct {logic ls; int cyc;} gnt_t;
  typedef struct {logic ls; logic err; logic [31:0] data; int cyc;} rsp_t;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata;
  logic [31:0] rdata;
  logic        rerr;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, timeout_flg;

  logic        p_rst;
  logic        p_if_req, p_if_gnt, p_if_rvalid;
  logic [31:0] p_if_addr;
  logic        p_ls_req, p_ls_we, p_ls_gnt, p_ls_rvalid;
  logic [31:0] p_ls_addr, p_ls_wdata, p_rdata;
  logic        p_rerr;
  logic        p_mem_req, p_mem_we, p_mem_gnt, p_mem_rvalid;
  logic [31:0] p_mem_addr, p_mem_wdata, p_mem_rdata;
  logic        p_busy, p_timeout_flg;

  mem_arbiter #(.WIDTH(32), .DATA_PRIO(1'b0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .rdata(rdata), .rerr(rerr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_flg(timeout_flg)
  );

  mem_arbiter #(.WIDTH(32), .DATA_PRIO(1'b1), .TIMEOUT(255)) dut_prio (
    .clk(clk), .rst(p_rst),
    .if_req(p_if_req), .if_addr(p_if_addr), .if_gnt(p_if_gnt), .if_rvalid(p_if_rvalid),
    .ls_req(p_ls_req), .ls_we(p_ls_we), .ls_addr(p_ls_addr), .ls_wdata(p_ls_wdata),
    .ls_gnt(p_ls_gnt), .ls_rvalid(p_ls_rvalid), .rdata(p_rdata), .rerr(p_rerr),
    .mem_req(p_mem_req), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_gnt(p_mem_gnt), .mem_rvalid(p_mem_rvalid), .mem_rdata(p_mem_rdata),
    .busy(p_busy), .timeout_flg(p_timeout_flg)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  req_t exp_req[$];
  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];

  // Reference model state
  logic        if_pend = 1'b0, ls_pend = 1'b0;
  logic        last_ls = 1'b1;
  logic        exp_flg = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no pending expectation (cycle %0d)", name, cyc);
  endtask

  // Monitor
  req_t cur;
  gnt_t eg;
  rsp_t er;
  logic req_act = 1'b0;

  always @(negedge clk) begin
    if (!mon_en) begin
      req_act = 1'b0;
    end else begin
      if (mem_req) begin
        if (!req_act) begin
          if (exp_req.size() == 0) flag("mem_req_unexpected");
          else begin
            cur = exp_req.pop_front();
            req_act = 1'b1;
            chk("mem_req_cycle", 32'(cyc), 32'(cur.cyc));
          end
        end
        if (req_act) begin
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wdata", mem_wdata, cur.wdata);
          if (mem_gnt) req_act = 1'b0;
        end
      end else if (req_act) begin
        checks++;
        errors++;
        $display("FAIL mem_req_held: got 0, expected 1 (cycle %0d)", cyc);
        req_act = 1'b0;
      end
      if (if_gnt || ls_gnt) begin
        if (exp_gnt.size() == 0) flag("gnt_unexpected");
        else begin
          eg = exp_gnt.pop_front();
          chk("gnt_owner", 32'({if_gnt, ls_gnt}), eg.ls ? 32'd1 : 32'd2);
          chk("gnt_cycle", 32'(cyc), 32'(eg.cyc));
        end
      end
      if (if_rvalid || ls_rvalid) begin
        if (exp_rsp.size() == 0) flag("rvalid_unexpected");
        else begin
          er = exp_rsp.pop_front();
          chk("rsp_owner", 32'({if_rvalid, ls_rvalid}), er.ls ? 32'd1 : 32'd2);
          chk("rsp_cycle", 32'(cyc), 32'(er.cyc));
          chk("rsp_rerr", 32'(rerr), 32'(er.err));
          chk("rsp_rdata", rdata, er.data);
        end
      end else begin
        chk("rdata_idle", rdata, 32'h0);
        chk("rerr_idle", 32'(rerr), 32'd0);
      end
    end
  end

  // One arbitration round plus memory behaviour. Called #1 after a posedge with the DUT idle.
  // rdly = WAIT_RESP cycle index of mem_rvalid; rdly >= TO means memory never answers.
  task automatic run_txn(input logic add_if, input logic add_ls, input int gap, input int gdly,
                         input int rdly, input logic [31:0] ia, input logic lwe,
                         input logic [31:0] la, input logic [31:0] lwd, input logic [31:0] rd);
    logic win_ls;
    int   a, g;
    if (!if_pend && !ls_pend) repeat (gap) begin @(posedge clk); #1; end
    if (add_if && !if_pend) begin if_pend = 1'b1; if_addr = ia; end
    if (add_ls && !ls_pend) begin
      ls_pend = 1'b1; ls_we = lwe; ls_addr = la; ls_wdata = lwd;
    end
    if (!if_pend && !ls_pend) begin if_pend = 1'b1; if_addr = ia; end
    if_req = if_pend;
    ls_req = ls_pend;
    // A lone request wins; a tie goes to whoever was not served last.
    win_ls  = (if_pend && ls_pend) ? !last_ls : ls_pend;
    last_ls = win_ls;
    a = cyc;
    exp_req.push_back('{we: win_ls && ls_we, addr: win_ls ? ls_addr : if_addr,
                        wdata: win_ls ? ls_wdata : 32'h0, cyc: a + 1});
    @(posedge clk); #1;
    chk("busy_issue", 32'(busy), 32'd1);
    repeat (gdly) begin @(posedge clk); #1; end
    g = cyc;
    exp_gnt.push_back('{ls: win_ls, cyc: g});
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (win_ls) begin ls_pend = 1'b0; ls_req = 1'b0; end
    else begin if_pend = 1'b0; if_req = 1'b0; end
    if (rdly < TO) begin
      repeat (rdly) begin @(posedge clk); #1; end
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      exp_rsp.push_back('{ls: win_ls, err: 1'b0, data: rd, cyc: cyc});
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end else begin
      exp_rsp.push_back('{ls: win_ls, err: 1'b1, data: 32'h0, cyc: g + TO});
      repeat (TO) begin @(posedge clk); #1; end
      exp_flg = 1'b1;
    end
    chk("busy_idle", 32'(busy), 32'd0);
    chk("timeout_flg", 32'(timeout_flg), 32'(exp_flg));
  endtask

  int gd;
  int t;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = '0; ls_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    p_rst = 1'b1; p_if_req = 1'b0; p_if_addr = '0; p_ls_req = 1'b0; p_ls_we = 1'b0;
    p_ls_addr = '0; p_ls_wdata = '0; p_mem_gnt = 1'b0; p_mem_rvalid = 1'b0; p_mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_flg", 32'(timeout_flg), 32'd0);
    chk("rst_gnt_rvalid", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid}), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rerr", 32'(rerr), 32'd0);
    rst = 1'b0;
    p_rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // IF read, immediate grant, response two cycles after the grant
    run_txn(1'b1, 1'b0, 0, 0, 1, 32'h100, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
    // Held ties alternate owners
    for (int i = 0; i < 6; i++)
      run_txn(1'b1, 1'b1, 0, 0, 0, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom);
    while (if_pend || ls_pend) run_txn(1'b0, 1'b0, 0, 0, 0, $urandom, 1'b0, 32'h0, 32'h0, $urandom);
    // LS write with a 5-cycle grant stall
    run_txn(1'b0, 1'b1, 0, 5, 0, $urandom, 1'b1, 32'h40, 32'h1234, $urandom);
    // Timeout, response exactly on the timeout cycle, and LS timeout
    run_txn(1'b1, 1'b0, 0, 0, TO, $urandom, 1'b0, 32'h0, 32'h0, $urandom);
    run_txn(1'b0, 1'b1, 0, 1, TO - 1, $urandom, 1'b0, $urandom, $urandom, $urandom);
    run_txn(1'b0, 1'b1, 1, 0, TO + 1, $urandom, 1'b1, $urandom, $urandom, $urandom);

    for (int i = 0; i < 3000; i++) begin
      gd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 2));
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), gd,
              int'($urandom_range(0, TO + 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
              $urandom, $urandom);
    end
    while (if_pend || ls_pend) run_txn(1'b0, 1'b0, 0, 0, 0, $urandom, 1'b0, 32'h0, 32'h0, $urandom);

    // Reset in the middle of WAIT_RESP, then a stray response
    mon_en = 1'b0;
    if_req = 1'b1; if_addr = 32'h200;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; if_req = 1'b0;
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_mem_req", 32'(mem_req), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_flg", 32'(timeout_flg), 32'd0);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    #1;
    chk("stray_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
    chk("stray_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("stray_flg", 32'(timeout_flg), 32'd1);
    chk("stray_busy", 32'(busy), 32'd0);
    exp_flg = 1'b1;
    last_ls = 1'b1;
    mon_en  = 1'b1;
    // First tie after reset goes to IF
    run_txn(1'b1, 1'b1, 0, 0, 0, $urandom, 1'b0, $urandom, $urandom, $urandom);
    while (if_pend || ls_pend) run_txn(1'b0, 1'b0, 0, 0, 0, $urandom, 1'b0, 32'h0, 32'h0, $urandom);

    // Data-priority instance: held ties always go to LS
    p_if_req = 1'b1; p_if_addr = $urandom;
    p_ls_req = 1'b1; p_ls_addr = $urandom; p_ls_wdata = $urandom;
    p_mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!(p_if_gnt || p_ls_gnt) && t < 6) begin @(posedge clk); #1; t++; end
      chk("prio_gnt", 32'({p_if_gnt, p_ls_gnt}), 32'd1);
      @(posedge clk); #1;
      p_mem_rvalid = 1'b1; p_mem_rdata = $urandom;
      #1;
      chk("prio_rvalid", 32'({p_if_rvalid, p_ls_rvalid}), 32'd1);
      chk("prio_rdata", p_rdata, p_mem_rdata);
      @(posedge clk); #1;
      p_mem_rvalid = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("exp_req_left", 32'(exp_req.size()), 32'd0);
    chk("exp_gnt_left", 32'(exp_gnt.size()), 32'd0);
    chk("exp_rsp_left", 32'(exp_rsp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
